ex_issue_stage: RTL and testbench
=================================

Name: ex_issue_stage

Overview:
- Execute-stage issue/retire block. Initiator side of the ALU interface.
- Accepts decoded micro-ops from ID over valid/ready and selects ALU operands.
- Drives the combinational ALU (instantiated inside) with operand_a, operand_b and alu_op, and consumes result, zero, less_than and less_than_unsigned.
- Resolves branches and jumps, and registers results into a one-entry EX/WB output stage with backpressure and flush.

Parameters:
- DATA_WIDTH, 32, datapath width (matches global define).
- RESET_PC_ZERO, 1, when 1, out_redirect_pc resets to 0.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  micro-op valid from ID
- in_ready  output  1  EX can accept this cycle
- in_pc  input  DATA_WIDTH  instruction PC
- in_rs1_data  input  DATA_WIDTH  rs1 value
- in_rs2_data  input  DATA_WIDTH  rs2 value
- in_imm  input  DATA_WIDTH  sign-extended immediate
- in_alu_op  input  alu_op_t (4)  ALU operation
- in_src_a_sel  input  1  0 = rs1, 1 = pc
- in_src_b_sel  input  1  0 = rs2, 1 = imm
- in_rd  input  5  destination register
- in_rd_we  input  1  register write request
- in_is_branch  input  1  conditional branch
- in_br_funct3  input  3  branch condition
- in_is_jump  input  1  JAL/JALR
- flush  input  1  kill the in-flight entry and refuse input
- out_valid  output  1  registered entry valid to WB
- out_ready  input  1  WB accepts
- out_result  output  DATA_WIDTH  writeback value
- out_rd  output  5  destination
- out_rd_we  output  1  qualified write enable
- out_redirect  output  1  control transfer taken
- out_redirect_pc  output  DATA_WIDTH  redirect target

Behaviour:
- ALU inputs:
  - operand_a = in_src_a_sel ? in_pc : in_rs1_data
  - operand_b = in_src_b_sel ? in_imm : in_rs2_data
  - alu_op = in_alu_op
  - Purely combinational from the in_* ports; no latency inside EX.
- in_ready = !flush && (!out_valid || out_ready).
- Accept = in_valid && in_ready. On accept, all out_* registers load on the next edge, so latency is 1 cycle from accept to out_valid.
- Hold: while out_valid && !out_ready, every out_* holds stable and in_ready = 0.
- Drain: out_valid && out_ready && !accept → out_valid = 0 next cycle. Drain plus accept in the same cycle gives back-to-back entries with no bubble.
- Flush has priority over accept and hold: out_valid = 0 next cycle and no entry is captured that cycle. Other out_* fields may hold stale values.
- Branch (in_is_branch = 1):
  - Decoder supplies ALU_SUB with rs1/rs2.
  - Taken per funct3: 000 zero; 001 !zero; 100 less_than; 101 !less_than; 110 less_than_unsigned; 111 !less_than_unsigned.
  - 010/011: not taken.
  - target = in_pc + in_imm, computed by a dedicated adder mod 2^DATA_WIDTH.
  - out_rd_we = 0.
- Jump (in_is_jump = 1):
  - ALU computes the target (pc+imm or rs1+imm).
  - out_redirect = 1.
  - out_redirect_pc = ALU result with bit 0 cleared.
  - out_result = in_pc + 4, wrapping at 2^DATA_WIDTH.
- in_is_branch and in_is_jump both set: jump wins and the branch condition is ignored.
- Otherwise: out_result = ALU result and out_redirect = 0.
- out_rd_we = in_rd_we && (in_rd != 0) && !in_is_branch.
- Redirect not taken: out_redirect_pc = in_pc + 4.
- out_redirect is only meaningful while out_valid = 1.
- Reset (sync, mid-operation included):
  - out_valid = 0, out_redirect = 0, out_rd_we = 0.
  - out_result = 0, out_rd = 0, out_redirect_pc = 0.
  - in_ready = 1 in the first cycle after reset, provided flush = 0.
- Simultaneous rst and flush: rst dominates.

Test Plan:
- ADDI: rs1 = 0x0000_0010, imm = 0xFFFF_FFFF, src_b = imm, op ADD, rd = 5 → one cycle later out_valid = 1, out_result = 0x0000_000F, out_rd_we = 1, out_redirect = 0.
- Backpressure: hold out_ready = 0 for 3 cycles with in_valid = 1 → in_ready = 0 and out_* stable. Raise out_ready → next micro-op is accepted the same cycle with no bubble. Stream of 4 ops retires in order.
- Branch signed vs unsigned: rs1 = 0xFFFF_FFFF, rs2 = 1, SUB.
  - funct3 = 100 → redirect = 1, redirect_pc = pc + imm.
  - funct3 = 110 → redirect = 0, redirect_pc = pc + 4.
  - Both cases: rd_we = 0.
- JALR: rs1 = 0x0000_1003, imm = 4, pc = 0x200, rd = 1 → redirect_pc = 0x0000_1006, out_result = 0x204, rd_we = 1. Same op with rd = 0 → rd_we = 0.
- Flush: with out_valid = 1 and out_ready = 0, assert flush one cycle while in_valid = 1 → in_ready = 0 that cycle, out_valid = 0 next cycle, no new entry captured.
- Reset mid-stream: assert rst while out_valid = 1 and redirect = 1 → next cycle all outputs 0 and in_ready = 1. PC wrap: pc = 0xFFFF_FFFC jump → out_result = 0x0000_0000.

Source files
------------

// File: rtl/ex_issue_stage.sv
// ex_issue_stage: execute-stage issue/retire block (initiator side of the ALU).
//
// Accepts decoded micro-ops from ID over valid/ready, selects ALU operands,
// resolves branches and jumps, and registers the outcome into a one-entry
// EX/WB output stage with backpressure and flush.
//
// ALU op encoding (alu_op_t, 4 bits):
//   0 ADD   1 SUB   2 SLL   3 SLT   4 SLTU  5 XOR   6 SRL   7 SRA
//   8 OR    9 AND  10 PASS_B (LUI)   11..15 result 0
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   micro-op handshake from ID
//   in_pc, in_rs1_data, in_rs2_data, in_imm   operand sources
//   in_alu_op, in_src_a_sel, in_src_b_sel     ALU control
//   in_rd, in_rd_we                           destination
//   in_is_branch, in_br_funct3, in_is_jump    control-transfer info
//   flush                                     kill in-flight entry, refuse input
//   out_valid/out_ready                       EX/WB handshake
//   out_result, out_rd, out_rd_we             writeback payload
//   out_redirect, out_redirect_pc             control-transfer outcome

module ex_alu #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [3:0]            alu_op,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  zero,
    output logic                  less_than,
    output logic                  less_than_unsigned
);
    localparam int SHW = $clog2(DATA_WIDTH);

    logic [SHW-1:0] shamt;

    assign shamt              = operand_b[SHW-1:0];
    assign less_than          = $signed(operand_a) < $signed(operand_b);
    assign less_than_unsigned = operand_a < operand_b;
    assign zero               = (result == '0);

    always_comb begin
        result = '0;
        case (alu_op)
            4'd0:    result = operand_a + operand_b;
            4'd1:    result = operand_a - operand_b;
            4'd2:    result = operand_a << shamt;
            4'd3:    result = {{(DATA_WIDTH-1){1'b0}}, less_than};
            4'd4:    result = {{(DATA_WIDTH-1){1'b0}}, less_than_unsigned};
            4'd5:    result = operand_a ^ operand_b;
            4'd6:    result = operand_a >> shamt;
            4'd7:    result = DATA_WIDTH'($signed(operand_a) >>> shamt);
            4'd8:    result = operand_a | operand_b;
            4'd9:    result = operand_a & operand_b;
            4'd10:   result = operand_b;
            default: result = '0;
        endcase
    end
endmodule

module ex_issue_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter bit RESET_PC_ZERO = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_pc,
    input  logic [DATA_WIDTH-1:0] in_rs1_data,
    input  logic [DATA_WIDTH-1:0] in_rs2_data,
    input  logic [DATA_WIDTH-1:0] in_imm,
    input  logic [3:0]            in_alu_op,
    input  logic                  in_src_a_sel,
    input  logic                  in_src_b_sel,
    input  logic [4:0]            in_rd,
    input  logic                  in_rd_we,
    input  logic                  in_is_branch,
    input  logic [2:0]            in_br_funct3,
    input  logic                  in_is_jump,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic [4:0]            out_rd,
    output logic                  out_rd_we,
    output logic                  out_redirect,
    output logic [DATA_WIDTH-1:0] out_redirect_pc
);
    logic [DATA_WIDTH-1:0] operand_a;
    logic [DATA_WIDTH-1:0] operand_b;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_zero;
    logic                  alu_lt;
    logic                  alu_ltu;

    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0] br_target;
    logic                  br_taken;
    logic                  accept;

    logic [DATA_WIDTH-1:0] nxt_result;
    logic                  nxt_redirect;
    logic [DATA_WIDTH-1:0] nxt_redirect_pc;
    logic                  nxt_rd_we;

    assign operand_a = in_src_a_sel ? in_pc  : in_rs1_data;
    assign operand_b = in_src_b_sel ? in_imm : in_rs2_data;

    ex_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .alu_op             (in_alu_op),
        .operand_a          (operand_a),
        .operand_b          (operand_b),
        .result             (alu_result),
        .zero               (alu_zero),
        .less_than          (alu_lt),
        .less_than_unsigned (alu_ltu)
    );

    // flush gates in_ready, so accept never coincides with flush.
    assign in_ready = !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Dedicated adders: branch target and link / fall-through address.
    assign pc_plus4  = in_pc + DATA_WIDTH'(4);
    assign br_target = in_pc + in_imm;

    always_comb begin
        br_taken = 1'b0;
        case (in_br_funct3)
            3'b000:  br_taken = alu_zero;
            3'b001:  br_taken = !alu_zero;
            3'b100:  br_taken = alu_lt;
            3'b101:  br_taken = !alu_lt;
            3'b110:  br_taken = alu_ltu;
            3'b111:  br_taken = !alu_ltu;
            default: br_taken = 1'b0;
        endcase
    end

    // Jump takes precedence over branch when both flags are set.
    always_comb begin
        nxt_result      = alu_result;
        nxt_redirect    = 1'b0;
        nxt_redirect_pc = pc_plus4;
        if (in_is_jump) begin
            nxt_result      = pc_plus4;
            nxt_redirect    = 1'b1;
            nxt_redirect_pc = {alu_result[DATA_WIDTH-1:1], 1'b0};
        end else if (in_is_branch) begin
            nxt_redirect    = br_taken;
            nxt_redirect_pc = br_taken ? br_target : pc_plus4;
        end
        nxt_rd_we = in_rd_we && (in_rd != 5'd0) && !in_is_branch;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Payload only loads on accept; it holds (or goes stale after flush) otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_result   <= '0;
            out_rd       <= '0;
            out_rd_we    <= 1'b0;
            out_redirect <= 1'b0;
            if (RESET_PC_ZERO) begin
                out_redirect_pc <= '0;
            end
        end else if (accept) begin
            out_result      <= nxt_result;
            out_rd          <= in_rd;
            out_rd_we       <= nxt_rd_we;
            out_redirect    <= nxt_redirect;
            out_redirect_pc <= nxt_redirect_pc;
        end
    end
endmodule

// File: tb/tb_ex_issue_stage.sv
module tb_ex_issue_stage;
    localparam int DW = 32;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [3:0]  op;
        logic        src_a;
        logic        src_b;
        logic [4:0]  rd;
        logic        rd_we;
        logic        is_branch;
        logic [2:0]  f3;
        logic        is_jump;
    } op_t;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        rd_we;
        logic        redirect;
        logic [31:0] redirect_pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic        out_redirect;
    logic [31:0] out_redirect_pc;
    op_t         cur;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic exp_valid;

    always #5 clk = ~clk;

    ex_issue_stage #(.DATA_WIDTH(DW), .RESET_PC_ZERO(1'b1)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_pc           (cur.pc),
        .in_rs1_data     (cur.rs1),
        .in_rs2_data     (cur.rs2),
        .in_imm          (cur.imm),
        .in_alu_op       (cur.op),
        .in_src_a_sel    (cur.src_a),
        .in_src_b_sel    (cur.src_b),
        .in_rd           (cur.rd),
        .in_rd_we        (cur.rd_we),
        .in_is_branch    (cur.is_branch),
        .in_br_funct3    (cur.f3),
        .in_is_jump      (cur.is_jump),
        .flush           (flush),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_result      (out_result),
        .out_rd          (out_rd),
        .out_rd_we       (out_rd_we),
        .out_redirect    (out_redirect),
        .out_redirect_pc (out_redirect_pc)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: what the micro-op means architecturally.
    function automatic exp_t model(input op_t o);
        exp_t        e;
        logic [31:0] a, b, alu;
        bit          taken;
        a = o.src_a ? o.pc  : o.rs1;
        b = o.src_b ? o.imm : o.rs2;
        case (o.op)
            4'd0:    alu = a + b;
            4'd1:    alu = a - b;
            4'd2:    alu = a << b[4:0];
            4'd3:    alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd4:    alu = (a < b) ? 32'd1 : 32'd0;
            4'd5:    alu = a ^ b;
            4'd6:    alu = a >> b[4:0];
            4'd7:    alu = $signed(a) >>> b[4:0];
            4'd8:    alu = a | b;
            4'd9:    alu = a & b;
            4'd10:   alu = b;
            default: alu = 32'd0;
        endcase
        case (o.f3)
            3'd0:    taken = (a == b);
            3'd1:    taken = (a != b);
            3'd4:    taken = ($signed(a) <  $signed(b));
            3'd5:    taken = ($signed(a) >= $signed(b));
            3'd6:    taken = (a <  b);
            3'd7:    taken = (a >= b);
            default: taken = 1'b0;
        endcase
        e.rd    = o.rd;
        e.rd_we = o.rd_we && (o.rd != 0) && !o.is_branch;
        if (o.is_jump) begin
            e.result      = o.pc + 32'd4;
            e.redirect    = 1'b1;
            e.redirect_pc = alu & ~32'd1;
        end else if (o.is_branch) begin
            e.result      = alu;
            e.redirect    = taken;
            e.redirect_pc = taken ? o.pc + o.imm : o.pc + 32'd4;
        end else begin
            e.result      = alu;
            e.redirect    = 1'b0;
            e.redirect_pc = o.pc + 32'd4;
        end
        return e;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.pc        = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + {$urandom_range(0, 3), 2'b00}
                                                  : {$urandom, 2'b00};
        o.rs1       = ($urandom_range(0, 3) == 0) ? o.pc : $urandom;
        o.rs2       = ($urandom_range(0, 3) == 0) ? o.rs1 : $urandom;
        o.imm       = $urandom;
        o.op        = 4'($urandom_range(0, 15));
        o.src_a     = 1'($urandom_range(0, 1));
        o.src_b     = 1'($urandom_range(0, 1));
        o.rd        = 5'($urandom_range(0, 31));
        o.rd_we     = 1'($urandom_range(0, 1));
        o.is_branch = ($urandom_range(0, 3) == 0);
        o.f3        = 3'($urandom_range(0, 7));
        o.is_jump   = ($urandom_range(0, 5) == 0);
        if (o.is_branch) begin
            o.op    = 4'd1;
            o.src_a = 1'b0;
            o.src_b = 1'b0;
        end
        return o;
    endfunction

    function automatic op_t zero_op();
        op_t o;
        o = '{default: '0};
        return o;
    endfunction

    // One clock: check handshake against the occupancy model at negedge,
    // record accepted ops, then return just after the next rising edge.
    task automatic cycle();
        logic rdy;
        @(negedge clk);
        if (rst) begin
            exp_valid = 1'b0;
        end else begin
            check("out_valid", 32'(out_valid), 32'(exp_valid));
            rdy = !flush && (!exp_valid || out_ready);
            check("in_ready", 32'(in_ready), 32'(rdy));
            if (in_valid && rdy) exp_q.push_back(model(cur));
            if (flush) exp_valid = 1'b0;
            else if (in_valid && rdy) exp_valid = 1'b1;
            else if (out_ready) exp_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: retire / kill entries and check that stalled outputs hold.
    exp_t h;
    bit   have_hold = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            have_hold = 0;
        end else begin
            if (have_hold) begin
                check("hold_valid",  32'(out_valid),    32'd1);
                check("hold_result", out_result,        h.result);
                check("hold_rd",     32'(out_rd),       32'(h.rd));
                check("hold_rd_we",  32'(out_rd_we),    32'(h.rd_we));
                check("hold_redir",  32'(out_redirect), 32'(h.redirect));
                check("hold_rpc",    out_redirect_pc,   h.redirect_pc);
            end
            if (out_valid && (out_ready || flush)) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_underflow: out_valid with no expected entry at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    if (out_ready) begin
                        check("sb_result", out_result,        e.result);
                        check("sb_rd",     32'(out_rd),       32'(e.rd));
                        check("sb_rd_we",  32'(out_rd_we),    32'(e.rd_we));
                        check("sb_redir",  32'(out_redirect), 32'(e.redirect));
                        check("sb_rpc",    out_redirect_pc,   e.redirect_pc);
                    end
                end
            end
            have_hold = out_valid && !out_ready && !flush;
            h.result      = out_result;
            h.rd          = out_rd;
            h.rd_we       = out_rd_we;
            h.redirect    = out_redirect;
            h.redirect_pc = out_redirect_pc;
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        exp_valid = 1'b0;
        cur       = zero_op();
        cycle();
        cycle();
        rst = 1'b0;
        #1;
        check("rst_valid",  32'(out_valid),    32'd0);
        check("rst_result", out_result,        32'd0);
        check("rst_rd",     32'(out_rd),       32'd0);
        check("rst_rd_we",  32'(out_rd_we),    32'd0);
        check("rst_redir",  32'(out_redirect), 32'd0);
        check("rst_rpc",    out_redirect_pc,   32'd0);
        check("rst_ready",  32'(in_ready),     32'd1);

        // ADDI
        cur = zero_op();
        cur.pc = 32'h100; cur.rs1 = 32'h10; cur.imm = 32'hFFFF_FFFF;
        cur.src_b = 1'b1; cur.op = 4'd0; cur.rd = 5'd5; cur.rd_we = 1'b1;
        in_valid = 1'b1; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        check("addi_valid",  32'(out_valid),    32'd1);
        check("addi_result", out_result,        32'h0000_000F);
        check("addi_rd_we",  32'(out_rd_we),    32'd1);
        check("addi_redir",  32'(out_redirect), 32'd0);
        cycle();

        // Backpressure then a 4-op stream
        out_ready = 1'b0; in_valid = 1'b1;
        cur = rand_op();
        cycle();
        cur = rand_op();
        repeat (3) begin
            check("bp_in_ready", 32'(in_ready), 32'd0);
            cycle();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            cycle();
            cur = rand_op();
        end
        in_valid = 1'b0;
        cycle();
        cycle();

        // Branch signed vs unsigned
        cur = zero_op();
        cur.pc = 32'h400; cur.rs1 = 32'hFFFF_FFFF; cur.rs2 = 32'd1; cur.imm = 32'h40;
        cur.op = 4'd1; cur.is_branch = 1'b1; cur.f3 = 3'b100; cur.rd = 5'd7; cur.rd_we = 1'b1;
        in_valid = 1'b1;
        cycle();
        check("blt_redir", 32'(out_redirect), 32'd1);
        check("blt_rpc",   out_redirect_pc,   32'h440);
        check("blt_rd_we", 32'(out_rd_we),    32'd0);
        cur.f3 = 3'b110;
        cycle();
        check("bltu_redir", 32'(out_redirect), 32'd0);
        check("bltu_rpc",   out_redirect_pc,   32'h404);
        check("bltu_rd_we", 32'(out_rd_we),    32'd0);

        // JALR
        cur = zero_op();
        cur.pc = 32'h200; cur.rs1 = 32'h1003; cur.imm = 32'd4; cur.src_b = 1'b1;
        cur.op = 4'd0; cur.is_jump = 1'b1; cur.rd = 5'd1; cur.rd_we = 1'b1;
        cycle();
        check("jalr_rpc",    out_redirect_pc,   32'h1006);
        check("jalr_result", out_result,        32'h204);
        check("jalr_rd_we",  32'(out_rd_we),    32'd1);
        check("jalr_redir",  32'(out_redirect), 32'd1);
        cur.rd = 5'd0;
        cycle();
        check("jalr_x0_rd_we", 32'(out_rd_we), 32'd0);
        in_valid = 1'b0;
        cycle();

        // Flush while stalled
        out_ready = 1'b0; in_valid = 1'b1;
        cur = rand_op();
        cycle();
        flush = 1'b1;
        cur = rand_op();
        #1;
        check("flush_in_ready", 32'(in_ready), 32'd0);
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check("flush_out_valid", 32'(out_valid), 32'd0);
        cycle();

        // Reset mid-stream with a taken jump in the output stage
        cur = zero_op();
        cur.pc = 32'h80; cur.imm = 32'h100; cur.src_a = 1'b1; cur.src_b = 1'b1;
        cur.is_jump = 1'b1; cur.rd = 5'd1; cur.rd_we = 1'b1;
        in_valid = 1'b1; out_ready = 1'b0;
        cycle();
        check("pre_rst_valid", 32'(out_valid),    32'd1);
        check("pre_rst_redir", 32'(out_redirect), 32'd1);
        rst = 1'b1; in_valid = 1'b0;
        cycle();
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_valid",  32'(out_valid),    32'd0);
        check("mid_rst_redir",  32'(out_redirect), 32'd0);
        check("mid_rst_rd_we",  32'(out_rd_we),    32'd0);
        check("mid_rst_result", out_result,        32'd0);
        check("mid_rst_rd",     32'(out_rd),       32'd0);
        check("mid_rst_rpc",    out_redirect_pc,   32'd0);
        check("mid_rst_ready",  32'(in_ready),     32'd1);

        // PC wrap on jump link
        cur = zero_op();
        cur.pc = 32'hFFFF_FFFC; cur.imm = 32'd8; cur.src_a = 1'b1; cur.src_b = 1'b1;
        cur.is_jump = 1'b1; cur.rd = 5'd3; cur.rd_we = 1'b1;
        in_valid = 1'b1; out_ready = 1'b1;
        cycle();
        check("wrap_result", out_result,      32'h0);
        check("wrap_rpc",    out_redirect_pc, 32'h4);
        in_valid = 1'b0;
        cycle();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cur       = rand_op();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            cycle();
        end

        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (3) cycle();
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
